// File: rtl/sync_fifo_flagged.sv
// Single-clock FIFO with a registered read port, occupancy count,
// programmable almost-full/almost-empty thresholds and sticky error flags.
module sync_fifo_flagged #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int AFULL_THRESH  = 12,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  err_clr
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] AFULL_LVL  = AFULL_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AEMPTY_LVL = AEMPTY_THRESH[ADDR_WIDTH:0];

  generate
    if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
      $error("sync_fifo_flagged: AFULL_THRESH out of range 1..DEPTH");
    end
    if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
      $error("sync_fifo_flagged: AEMPTY_THRESH out of range 0..DEPTH-1");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic                  wr_accept;
  logic                  rd_accept;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign full  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                 (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  assign almost_full  = (count >= AFULL_LVL);
  assign almost_empty = (count <= AEMPTY_LVL);

  assign wr_accept = wr_en && !full;
  assign rd_accept = rd_en && !empty;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_accept;
      if (wr_accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_accept) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_data <= mem[rd_ptr[ADDR_WIDTH-1:0]];
      end
      case ({wr_accept, rd_accept})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A new error in the same cycle as err_clr takes priority over the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full) begin
        overflow <= 1'b1;
      end else if (err_clr) begin
        overflow <= 1'b0;
      end
      if (rd_en && empty) begin
        underflow <= 1'b1;
      end else if (err_clr) begin
        underflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo_flagged.sv
// Bench for sync_fifo_flagged: queue-based reference model, read-data
// scoreboard, a vector table for the fill/overflow phase, and corner sequences.
module tb_sync_fifo_flagged;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;
  logic       err_clr;

  sync_fifo_flagged dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow),
    .err_clr      (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0] model_q[$];
  logic [7:0] sb_q[$];
  logic [7:0] last_rd;
  bit         exp_valid;
  bit         model_ovf;
  bit         model_unf;

  typedef struct {
    bit         wr;
    bit         rd;
    bit         clr;
    logic [7:0] data;
    int         exp_count;
    bit         exp_ovf;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every observable output against the reference model.
  task automatic check_output();
    logic [7:0] exp_rd;
    check("count", 32'(count), 32'(model_q.size()));
    check("full", 32'(full), 32'(model_q.size() == 16));
    check("empty", 32'(empty), 32'(model_q.size() == 0));
    check("almost_full", 32'(almost_full), 32'(model_q.size() >= 12));
    check("almost_empty", 32'(almost_empty), 32'(model_q.size() <= 2));
    check("overflow", 32'(overflow), 32'(model_ovf));
    check("underflow", 32'(underflow), 32'(model_unf));
    check("rd_valid", 32'(rd_valid), 32'(exp_valid));
    if (exp_valid) begin
      if (sb_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL scoreboard_empty: got read with no expected word");
      end else begin
        exp_rd  = sb_q.pop_front();
        last_rd = exp_rd;
      end
    end
    check("rd_data", 32'(rd_data), 32'(last_rd));
  endtask

  // Drive one cycle of stimulus, advance the model, then check after the edge.
  task automatic apply_stimulus(input bit wr, input bit rd, input bit clr, input logic [7:0] d);
    bit mfull;
    bit mempty;
    bit wa;
    bit ra;
    wr_en   = wr;
    rd_en   = rd;
    err_clr = clr;
    wr_data = d;
    mfull  = (model_q.size() == 16);
    mempty = (model_q.size() == 0);
    wa = wr && !mfull;
    ra = rd && !mempty;
    if (ra) sb_q.push_back(model_q.pop_front());
    if (wa) model_q.push_back(d);
    if (wr && mfull) model_ovf = 1'b1;
    else if (clr)    model_ovf = 1'b0;
    if (rd && mempty) model_unf = 1'b1;
    else if (clr)     model_unf = 1'b0;
    exp_valid = ra;
    @(posedge clk);
    #1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    err_clr = 1'b0;
    check_output();
  endtask

  // Asynchronous reset asserted between edges and checked before the next edge.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    model_q.delete();
    sb_q.delete();
    model_ovf = 1'b0;
    model_unf = 1'b0;
    exp_valid = 1'b0;
    last_rd   = 8'h00;
    #1;
    check_output();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n   = 1'b1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    err_clr = 1'b0;
    wr_data = 8'h00;
    for (int i = 0; i < 16; i++) begin
      vecs[i] = '{wr: 1'b1, rd: 1'b0, clr: 1'b0, data: 8'(i), exp_count: i + 1, exp_ovf: 1'b0};
    end
    vecs[16] = '{wr: 1'b1, rd: 1'b0, clr: 1'b0, data: 8'hAA, exp_count: 16, exp_ovf: 1'b1};
    vecs[17] = '{wr: 1'b0, rd: 1'b0, clr: 1'b1, data: 8'h00, exp_count: 16, exp_ovf: 1'b0};

    @(posedge clk);
    #1;
    do_reset();

    // Fill to full, attempt an overflow write, then clear the flag.
    for (int i = 0; i < 18; i++) begin
      apply_stimulus(vecs[i].wr, vecs[i].rd, vecs[i].clr, vecs[i].data);
      check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
      check($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vecs[i].exp_ovf));
    end

    // Drain: 0x00..0x0F in order, never 0xAA.
    for (int i = 0; i < 16; i++) begin
      apply_stimulus(1'b0, 1'b1, 1'b0, 8'h00);
      check($sformatf("drain%0d_data", i), 32'(rd_data), 32'(i));
    end

    // Simultaneous write/read while empty: write wins, underflow set.
    apply_stimulus(1'b1, 1'b1, 1'b0, 8'h5C);
    apply_stimulus(1'b0, 1'b1, 1'b0, 8'h00);
    check("bypass_read", 32'(rd_data), 32'h5C);
    // Underflow set coinciding with err_clr must stay set, then clears.
    apply_stimulus(1'b0, 1'b1, 1'b1, 8'h00);
    apply_stimulus(1'b0, 1'b0, 1'b1, 8'h00);

    // Steady state at count 8 with 40 simultaneous transfers (pointers wrap).
    for (int i = 0; i < 8; i++) apply_stimulus(1'b1, 1'b0, 1'b0, 8'(8'h10 + i));
    for (int i = 0; i < 40; i++) apply_stimulus(1'b1, 1'b1, 1'b0, 8'(8'h18 + i));
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b1, 1'b0, 8'h00);

    // Mid-stream reset at count 5, then restart.
    check("pre_reset_count", 32'(count), 32'd5);
    do_reset();
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b0, 1'b0, 8'(8'hC0 + i));
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b1, 1'b0, 8'h00);

    // Full with simultaneous write/read: read accepted, write rejected.
    for (int i = 0; i < 16; i++) apply_stimulus(1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
    apply_stimulus(1'b1, 1'b1, 1'b0, 8'hEE);
    check("full_rw_data", 32'(rd_data), 32'h40);
    for (int i = 0; i < 15; i++) apply_stimulus(1'b0, 1'b1, 1'b0, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
